// File: rtl/regfile_writeback.sv
// Write-back queue for the 16 x 64-bit register file: load/ALU results are queued in order and
// presented on the write port until committed. Define REGS_WB_PENDING_EN to export pending_mask.
module regfile_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_enable,
    input  logic        mmu_ready,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_addr,
    input  logic [63:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_addr,
    input  logic [63:0] ld_data,
    output logic [3:0]  regD_addr,
    output logic [63:0] regD_data,
`ifdef REGS_WB_PENDING_EN
    output logic [15:0] pending_mask,
`endif
    output logic        reg_write_en
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [3:0]      addr_q [DEPTH];
    logic [63:0]     data_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic        full, empty;
    logic        ld_fire, alu_fire;
    logic        push, pop;
    logic [3:0]  push_addr;
    logic [63:0] push_data;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

    // Load unit has fixed priority; readies depend only on registered state and ld_valid.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;

    assign ld_fire  = ld_valid && ld_ready;
    assign alu_fire = alu_valid && alu_ready;

    always_comb begin
        push_addr = alu_addr;
        push_data = alu_data;
        if (ld_fire) begin
            push_addr = ld_addr;
            push_data = ld_data;
        end
    end

    // Writes to r0 complete the handshake but never occupy a slot.
    assign push = (ld_fire || alu_fire) && (push_addr != 4'd0);
    assign pop  = !empty && mmu_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clock_enable) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && clock_enable && push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    assign reg_write_en = !empty;
    assign regD_addr    = empty ? 4'd0 : addr_q[rd_ptr_q];
    assign regD_data    = empty ? 64'd0 : data_q[rd_ptr_q];

`ifdef REGS_WB_PENDING_EN
    logic [15:0]     mask;
    logic [PtrW-1:0] slot;

    always_comb begin
        mask = '0;
        slot = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot = rd_ptr_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                mask[addr_q[slot]] = 1'b1;
            end
        end
        mask[0] = 1'b0;
    end

    assign pending_mask = mask;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed vector table plus reset, mid-operation reset and random scoreboard sequences
// for regfile_writeback.
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n, clock_enable, mmu_ready;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [3:0]  alu_addr, ld_addr, regD_addr;
    logic [63:0] alu_data, ld_data, regD_data;
    logic        reg_write_en;
`ifdef REGS_WB_PENDING_EN
    logic [15:0] pending_mask;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_enable (clock_enable),
        .mmu_ready    (mmu_ready),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .regD_addr    (regD_addr),
        .regD_data    (regD_data),
`ifdef REGS_WB_PENDING_EN
        .pending_mask (pending_mask),
`endif
        .reg_write_en (reg_write_en)
    );

    typedef struct {
        logic        ce, mmu, ldv;
        logic [3:0]  lda;
        logic [63:0] ldd;
        logic        aluv;
        logic [3:0]  alua;
        logic [63:0] alud;
        logic        we;
        logic [3:0]  ea;
        logic [63:0] ed;
        logic        ardy, lrdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ce, input logic mmu, input logic ldv, input logic [3:0] lda,
                       input logic [63:0] ldd, input logic aluv, input logic [3:0] alua,
                       input logic [63:0] alud, input logic we, input logic [3:0] ea,
                       input logic [63:0] ed, input logic ardy, input logic lrdy);
        vec_t v;
        v.ce = ce; v.mmu = mmu; v.ldv = ldv; v.lda = lda; v.ldd = ldd;
        v.aluv = aluv; v.alua = alua; v.alud = alud;
        v.we = we; v.ea = ea; v.ed = ed; v.ardy = ardy; v.lrdy = lrdy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] outs();
        return {25'd0, reg_write_en, regD_addr, regD_data, alu_ready, ld_ready};
    endfunction

    task automatic idle_inputs();
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    endtask

    logic [67:0] sb[$];
    logic [67:0] head;
    logic        exp_full, exp_we, seen;
    int          xfers, cyc;

    initial begin
        reset_n = 1'b0; clock_enable = 1'b1; mmu_ready = 1'b1;
        idle_inputs();

        // Two reset cycles, then release
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("reset_outputs", outs(), {25'd0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b1});
`ifdef REGS_WB_PENDING_EN
        chk("reset_mask", {80'd0, pending_mask}, 96'd0);
`endif
        @(negedge clock);

        //  ce mmu ldv lda ldd    aluv alua alud          we ea ed            ardy lrdy
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);
        add(1, 1, 0, 0, 0,        1, 5, 64'hDEAD_BEEF,    0, 0, 0,            1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 5, 64'hDEAD_BEEF, 1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);
        add(1, 0, 1, 3, 1,        1, 4, 2,                0, 0, 0,            0, 1);
        add(1, 0, 0, 0, 0,        1, 4, 2,                1, 3, 1,            1, 1);
        add(1, 0, 0, 0, 0,        1, 6, 3,                1, 3, 1,            1, 1);
        add(1, 0, 1, 8, 4,        1, 9, 5,                1, 3, 1,            0, 1);
        add(1, 0, 1, 10, 6,       1, 11, 7,               1, 3, 1,            0, 0);
        add(1, 0, 1, 10, 6,       1, 11, 7,               1, 3, 1,            0, 0);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 3, 1,            0, 0);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 4, 2,            1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 6, 3,            1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 8, 4,            1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);
        add(1, 0, 1, 1, 11,       0, 0, 0,                0, 0, 0,            0, 1);
        add(1, 0, 1, 2, 12,       0, 0, 0,                1, 1, 11,           0, 1);
        add(1, 0, 1, 3, 13,       0, 0, 0,                1, 1, 11,           0, 1);
        add(1, 0, 1, 4, 14,       0, 0, 0,                1, 1, 11,           0, 1);
        add(1, 1, 1, 5, 15,       0, 0, 0,                1, 1, 11,           0, 0);
        add(1, 1, 1, 5, 15,       0, 0, 0,                1, 2, 12,           0, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 3, 13,           1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 4, 14,           1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 5, 15,           1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);
        add(1, 1, 1, 0, 1,        0, 0, 0,                0, 0, 0,            0, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);
        add(0, 1, 0, 0, 0,        1, 7, 77,               0, 0, 0,            1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);
        add(1, 1, 0, 0, 0,        1, 7, 77,               0, 0, 0,            1, 1);
        add(0, 1, 0, 0, 0,        0, 0, 0,                1, 7, 77,           1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                1, 7, 77,           1, 1);
        add(1, 1, 0, 0, 0,        0, 0, 0,                0, 0, 0,            1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            clock_enable = tbl[i].ce; mmu_ready = tbl[i].mmu;
            ld_valid = tbl[i].ldv; ld_addr = tbl[i].lda; ld_data = tbl[i].ldd;
            alu_valid = tbl[i].aluv; alu_addr = tbl[i].alua; alu_data = tbl[i].alud;
            #1;
            chk($sformatf("vec%0d", i), outs(),
                {25'd0, tbl[i].we, tbl[i].ea, tbl[i].ed, tbl[i].ardy, tbl[i].lrdy});
            @(negedge clock);
        end

        // Mid-operation reset with r7, r7, r9 queued
        idle_inputs();
        clock_enable = 1'b1; mmu_ready = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 64'd1;
        @(negedge clock);
        alu_data = 64'd2;
        @(negedge clock);
        alu_addr = 4'd9; alu_data = 64'd3;
        @(negedge clock);
        alu_valid = 1'b0;
        #1;
        chk("midrst_head", outs(), {25'd0, 1'b1, 4'd7, 64'd1, 1'b1, 1'b1});
`ifdef REGS_WB_PENDING_EN
        chk("midrst_mask", {80'd0, pending_mask}, {80'd0, 16'h0280});
`endif
        reset_n = 1'b0; mmu_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("midrst_after", outs(), {25'd0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b1});
`ifdef REGS_WB_PENDING_EN
        chk("midrst_mask_clr", {80'd0, pending_mask}, 96'd0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #1;
            if (reg_write_en === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_write", {95'd0, seen}, 96'd0);
        @(negedge clock);

        // Random transfers against a queue scoreboard
        xfers = 0;
        cyc = 0;
        while (xfers < 1000 && cyc < 20000) begin
            cyc++;
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr = 4'($urandom_range(0, 15));
            ld_data = {$urandom, $urandom};
            alu_valid = 1'($urandom_range(0, 1));
            alu_addr = 4'($urandom_range(0, 15));
            alu_data = {$urandom, $urandom};
            mmu_ready = ($urandom_range(0, 3) != 0);
            clock_enable = ($urandom_range(0, 7) != 0);
            #1;
            exp_full = (sb.size() == DEPTH);
            exp_we = (sb.size() != 0);
            head = exp_we ? sb[0] : 68'd0;
            chk("rand_out", outs(), {25'd0, exp_we, head, !exp_full && !ld_valid, !exp_full});
            if (clock_enable && mmu_ready && exp_we) void'(sb.pop_front());
            if (clock_enable && !exp_full) begin
                if (ld_valid) begin
                    xfers++;
                    if (ld_addr != 4'd0) sb.push_back({ld_addr, ld_data});
                end else if (alu_valid) begin
                    xfers++;
                    if (alu_addr != 4'd0) sb.push_back({alu_addr, alu_data});
                end
            end
            @(negedge clock);
        end
        chk("rand_budget", {95'd0, xfers >= 1000}, {95'd0, 1'b1});

        idle_inputs();
        mmu_ready = 1'b1; clock_enable = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            cyc++;
            #1;
            exp_we = (sb.size() != 0);
            head = exp_we ? sb[0] : 68'd0;
            chk("drain_out", outs(), {25'd0, exp_we, head, 1'b1, 1'b1});
            if (exp_we) void'(sb.pop_front());
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
